// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared lock-state encoding and PC constants for the locked PC unit
package lock_pkg;

    typedef enum logic [1:0] {
        LOCK_ST_LOCKED   = 2'b00,
        LOCK_ST_CHECK    = 2'b01,
        LOCK_ST_UNLOCKED = 2'b10,
        LOCK_ST_TAMPER   = 2'b11
    } lock_state_e;

    localparam int unsigned PC_STEP       = 4;
    // Low PC bits that must be zero on every fetch address
    localparam int unsigned PC_ALIGN_MASK = 3;

endpackage

// File: rtl/pc_key_checker.sv
// rtl/pc_key_checker.sv - key capture, one-cycle compare, retry counter and lock FSM
module pc_key_checker
    import lock_pkg::*;
#(
    parameter int unsigned          KEY_W     = 8,
    parameter logic [KEY_W-1:0]     KEY_VALUE = 8'hA3,
    parameter int unsigned          MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    input  logic             relock,
    output lock_state_e      state,
    output logic             key_ready,
    output logic             tamper
);

    localparam int unsigned     TRIES_W    = $clog2(MAX_TRIES + 1);
    // A mismatch seen while tries holds this value is the final permitted one
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

    logic [KEY_W-1:0]   key_reg;
    logic [TRIES_W-1:0] tries;

    // Lock FSM; key_ready and tamper are registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOCK_ST_LOCKED;
            key_reg   <= '0;
            tries     <= '0;
            key_ready <= 1'b1;
            tamper    <= 1'b0;
        end else begin
            case (state)
                LOCK_ST_LOCKED: begin
                    if (key_valid) begin
                        key_reg   <= key_in;
                        state     <= LOCK_ST_CHECK;
                        key_ready <= 1'b0;
                    end
                end
                LOCK_ST_CHECK: begin
                    if (key_reg == KEY_VALUE) begin
                        state <= LOCK_ST_UNLOCKED;
                        tries <= '0;
                    end else if (tries == TRIES_LAST) begin
                        state  <= LOCK_ST_TAMPER;
                        tries  <= tries + 1'b1;
                        tamper <= 1'b1;
                    end else begin
                        state     <= LOCK_ST_LOCKED;
                        tries     <= tries + 1'b1;
                        key_ready <= 1'b1;
                    end
                end
                LOCK_ST_UNLOCKED: begin
                    // tries is deliberately left alone so relocking cannot refresh the retry budget
                    if (relock) begin
                        state     <= LOCK_ST_LOCKED;
                        key_ready <= 1'b1;
                    end
                end
                default: begin
                    // Tamper is terminal until reset
                    state     <= LOCK_ST_TAMPER;
                    key_ready <= 1'b0;
                    tamper    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/locked_pc_unit.sv
// rtl/locked_pc_unit.sv - key-locked fetch program counter with redirect, stall and tamper lockout
module locked_pc_unit
    import lock_pkg::*;
#(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          KEY_W        = 8,
    parameter logic [KEY_W-1:0]     KEY_VALUE    = 8'hA3,
    parameter int unsigned          MAX_TRIES    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             relock,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic [1:0]       lock_state,
    output logic             tamper
);

    localparam logic [XLEN-1:0] ALIGN_KEEP = ~XLEN'(PC_ALIGN_MASK);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

    lock_state_e state;

    pc_key_checker #(
        .KEY_W     (KEY_W),
        .KEY_VALUE (KEY_VALUE),
        .MAX_TRIES (MAX_TRIES)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .relock    (relock),
        .state     (state),
        .key_ready (key_ready),
        .tamper    (tamper)
    );

    assign lock_state = state;
    assign pc_valid   = (state == LOCK_ST_UNLOCKED);

    // PC register: only moves while unlocked; relock > redirect > stall > increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VECTOR;
        end else if (state != LOCK_ST_UNLOCKED || relock) begin
            pc <= RESET_VECTOR;
        end else if (redirect) begin
            pc <= redirect_target & ALIGN_KEEP;
        end else if (!stall) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: tb/tb_locked_pc_unit.sv
// tb/tb_locked_pc_unit.sv - table-driven self-checking bench for locked_pc_unit
module tb_locked_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_in;
    logic        key_valid;
    logic        key_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        relock;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  lock_state;
    logic        tamper;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    locked_pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .KEY_W        (8),
        .KEY_VALUE    (8'hA3),
        .MAX_TRIES    (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .key_in          (key_in),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .relock          (relock),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .lock_state      (lock_state),
        .tamper          (tamper)
    );

    typedef struct {
        string       name;
        logic        kv;
        logic [7:0]  key;
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        rl;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [1:0]  e_state;
        logic        e_ready;
        logic        e_tamper;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic kv, logic [7:0] key, logic st, logic rd,
                                logic [31:0] tgt, logic rl, logic [31:0] e_pc, logic e_valid,
                                logic [1:0] e_state, logic e_ready, logic e_tamper);
        vec_t v;
        v.name = name; v.kv = kv; v.key = key; v.st = st; v.rd = rd; v.tgt = tgt; v.rl = rl;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_state = e_state; v.e_ready = e_ready;
        v.e_tamper = e_tamper;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic [31:0] e_pc, logic e_valid, logic [1:0] e_state,
                           logic e_ready, logic e_tamper);
        chk({name, ".pc"},        pc,                 e_pc);
        chk({name, ".pc_valid"},  32'(pc_valid),      32'(e_valid));
        chk({name, ".state"},     32'(lock_state),    32'(e_state));
        chk({name, ".key_ready"}, 32'(key_ready),     32'(e_ready));
        chk({name, ".tamper"},    32'(tamper),        32'(e_tamper));
    endtask

    task automatic drive(logic kv, logic [7:0] key, logic st, logic rd, logic [31:0] tgt, logic rl);
        key_valid = kv; key_in = key; stall = st; redirect = rd; redirect_target = tgt; relock = rl;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        //          name           kv key    st rd tgt           rl  pc            v  st    rdy tmp
        tbl.push_back(mk("unlock_key", 1, 8'hA3, 0, 0, 32'h0,        0, 32'h0,        0, 2'b01, 0, 0));
        tbl.push_back(mk("first_pc",   0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        1, 2'b10, 0, 0));
        tbl.push_back(mk("inc4",       0, 8'h00, 0, 0, 32'h0,        0, 32'h4,        1, 2'b10, 0, 0));
        tbl.push_back(mk("key_ignored",1, 8'h00, 0, 0, 32'h0,        0, 32'h8,        1, 2'b10, 0, 0));
        tbl.push_back(mk("incC",       0, 8'h00, 0, 0, 32'h0,        0, 32'hC,        1, 2'b10, 0, 0));
        tbl.push_back(mk("inc10",      0, 8'h00, 0, 0, 32'h0,        0, 32'h10,       1, 2'b10, 0, 0));
        tbl.push_back(mk("stall_redir",0, 8'h00, 1, 1, 32'h103,      0, 32'h100,      1, 2'b10, 0, 0));
        tbl.push_back(mk("stall_hold", 0, 8'h00, 1, 0, 32'h0,        0, 32'h100,      1, 2'b10, 0, 0));
        tbl.push_back(mk("redir_top",  0, 8'h00, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 2'b10, 0, 0));
        tbl.push_back(mk("wrap",       0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        1, 2'b10, 0, 0));
        tbl.push_back(mk("redir_20",   0, 8'h00, 0, 1, 32'h20,       0, 32'h20,       1, 2'b10, 0, 0));
        tbl.push_back(mk("relock",     0, 8'h00, 0, 1, 32'h40,       1, 32'h0,        0, 2'b00, 1, 0));
        tbl.push_back(mk("lk_ignore",  0, 8'h00, 1, 1, 32'h80,       1, 32'h0,        0, 2'b00, 1, 0));
        tbl.push_back(mk("rekey",      1, 8'hA3, 0, 0, 32'h0,        0, 32'h0,        0, 2'b01, 0, 0));
        tbl.push_back(mk("reunlock",   0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        1, 2'b10, 0, 0));
        tbl.push_back(mk("reinc",      0, 8'h00, 0, 0, 32'h0,        0, 32'h4,        1, 2'b10, 0, 0));
        tbl.push_back(mk("relock2",    0, 8'h00, 0, 0, 32'h0,        1, 32'h0,        0, 2'b00, 1, 0));
        tbl.push_back(mk("bad1",       1, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b01, 0, 0));
        tbl.push_back(mk("bad1_chk",   0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b00, 1, 0));
        tbl.push_back(mk("bad2",       1, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b01, 0, 0));
        tbl.push_back(mk("bad2_chk",   0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b00, 1, 0));
        tbl.push_back(mk("bad3",       1, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b01, 0, 0));
        tbl.push_back(mk("tamper",     0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b11, 0, 1));
        tbl.push_back(mk("tmp_key",    1, 8'hA3, 0, 1, 32'h44,       1, 32'h0,        0, 2'b11, 0, 1));
        tbl.push_back(mk("tmp_hold",   0, 8'h00, 0, 0, 32'h0,        0, 32'h0,        0, 2'b11, 0, 1));

        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].kv, tbl[i].key, tbl[i].st, tbl[i].rd, tbl[i].tgt, tbl[i].rl);
            @(posedge clk);
            #1;
            chk_all(tbl[i].name, tbl[i].e_pc, tbl[i].e_valid, tbl[i].e_state,
                    tbl[i].e_ready, tbl[i].e_tamper);
        end
        idle();

        // Asynchronous reset while in TAMPER, asserted between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk_all("arst_tamper", 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Asynchronous reset while in CHECK
        drive(1'b1, 8'hA3, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        chk_all("pre_arst_check", 32'h0, 1'b0, 2'b01, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("arst_check", 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Retry counter is cleared by reset: two wrong keys then the right one still unlocks
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'h5A, 1'b0, 1'b0, 32'h0, 1'b0);
            @(posedge clk);
            #1;
            idle();
            @(posedge clk);
            #1;
            chk_all("post_rst_bad", 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        drive(1'b1, 8'hA3, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        chk_all("post_rst_unlock", 32'h0, 1'b1, 2'b10, 1'b0, 1'b0);

        // Async reset while unlocked and running
        @(posedge clk);
        #3;
        chk("run_pc", pc, 32'h4);
        rst = 1'b0;
        #1;
        chk_all("arst_unlocked", 32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
